// File: rtl/fir_coe_loader.sv
`default_nettype none
// ============================================================================
// Module      : fir_coe_loader
// Description : Coefficient loader sitting upstream of the FIR filter. Takes
//               NUM_TAPS coefficient nibbles from the host over a valid/ready
//               handshake and replays each one to the FIR as a one-cycle
//               indexed write. After the final tap, it issues a one-cycle
//               commit index. A load that is aborted (timeout, restart or
//               reset) never produces a commit, so the FIR keeps its active
//               coefficient set.
// Ports       : clk          - single clock, shared with the FIR
//               rst          - synchronous active-high reset
//               cfg_start_i  - pulse that begins or restarts a load
//               cfg_valid_i  - cfg_data_i is valid
//               cfg_data_i   - coefficient nibble, tap 0 first
//               cfg_ready_o  - loader accepts cfg_data_i this cycle
//               count_coe_o  - FIR write index (0..NUM_TAPS-1 write,
//                              NUM_TAPS commit, IDLE_IDX none)
//               coe_o        - FIR coefficient data
//               busy_o       - load or commit in progress
//               done_o       - one-cycle pulse with the commit index
//               err_o        - one-cycle pulse on timeout abort
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coe_loader #(
    parameter int NUM_TAPS    = 11,
    parameter int COE_W       = 4,
    parameter int IDX_W       = 4,
    parameter int IDLE_IDX    = 15,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start_i,
    input  logic             cfg_valid_i,
    input  logic [COE_W-1:0] cfg_data_i,
    output logic             cfg_ready_o,
    output logic [IDX_W-1:0] count_coe_o,
    output logic [COE_W-1:0] coe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] C_COMMIT_IDX = IDX_W'(NUM_TAPS);
    localparam logic [IDX_W-1:0] C_IDLE_IDX   = IDX_W'(IDLE_IDX);
    localparam logic [TMR_W-1:0] C_TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [IDX_W-1:0]   count_q, count_d;
    logic [COE_W-1:0]   coe_q, coe_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               w_accept;

    // ready_q is only ever high in LOAD, so this is the handshake as seen
    // by the host at the same edge.
    assign w_accept = cfg_valid_i & ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            count_q <= C_IDLE_IDX;
            coe_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            count_q <= count_d;
            coe_q   <= coe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        // Writes last exactly one cycle: the index falls back to idle unless
        // this edge carries a new write or the commit.
        count_d = C_IDLE_IDX;
        coe_d   = coe_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start_i) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    timer_d = '0;
                end
            end
            ST_LOAD: begin
                if (cfg_start_i) begin
                    // Restart wins over a coincident accept; that nibble is lost.
                    idx_d   = '0;
                    timer_d = '0;
                end else if (w_accept) begin
                    count_d = idx_q;
                    coe_d   = cfg_data_i;
                    timer_d = '0;
                    if (idx_q == C_LAST_IDX) begin
                        state_d = ST_COMMIT;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end else if (timer_q == C_TMR_LAST) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    timer_d = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_COMMIT: begin
                count_d = C_COMMIT_IDX;
                coe_d   = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // with the state they describe.
        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
    end

    assign cfg_ready_o = ready_q;
    assign count_coe_o = count_q;
    assign coe_o       = coe_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire
